// File: rtl/approx_adder_tree_pipe.sv
// rtl/approx_adder_tree_pipe.sv - pipelined lower-part-OR approximate adder tree (option macro: ATREE_EXACT_MODE_EN)
module approx_adder_tree_pipe #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int K = 3,
  localparam int L  = $clog2(N),
  localparam int OW = W + L
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic          approx_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] y
);

  // Bit offset of level j inside the flattened tree bus (level 0 is the raw operand set).
  function automatic int lvl_off(input int j);
    int s;
    s = 0;
    for (int t = 0; t < j; t++) s += (N >> t) * (W + t);
    return s;
  endfunction

  localparam int TOT = lvl_off(L + 1);

  // All levels side by side: level j holds N>>j sums of W+j bits each.
  logic [TOT-1:0] w_tree;
  logic [L:0]     w_vld;
  logic           w_stall;
  logic           w_unused;

  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = w_vld[L];
  assign y         = w_tree[lvl_off(L) +: OW];

  assign w_tree[lvl_off(0) +: N*W] = in_data;
  assign w_vld[0]                  = in_valid;

`ifdef ATREE_EXACT_MODE_EN
  // Mode bit per level travels with its operand set; the last level's copy has no consumer.
  logic [L:0] w_mode;
  assign w_mode[0] = approx_en;
  assign w_unused  = w_mode[L];
`else
  assign w_unused  = approx_en;
`endif

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int NJ = N >> j;
    localparam int WJ = W + j;
    localparam int WI = WJ - 1;
    localparam int PO = lvl_off(j - 1);
    localparam int CO = lvl_off(j);

    logic [NJ*WJ-1:0] w_next;
    logic [NJ*WJ-1:0] r_q;
    logic             r_vld;

    for (genvar i = 0; i < NJ; i++) begin : g_node
      logic [WI-1:0] w_a;
      logic [WI-1:0] w_b;
      logic [WI:0]   w_sum;

      assign w_a = w_tree[PO + (2*i)*WI +: WI];
      assign w_b = w_tree[PO + (2*i+1)*WI +: WI];

      if (K == 0) begin : g_full
        assign w_sum = {1'b0, w_a} + {1'b0, w_b};
      end else begin : g_loa
        logic [WI-K:0] w_hi;
        logic [WI:0]   w_loa;
        // Low K bits are ORed; their top bit pair generates the only carry into the exact upper part.
        assign w_hi  = {1'b0, w_a[WI-1:K]} + {1'b0, w_b[WI-1:K]}
                     + {{(WI-K){1'b0}}, w_a[K-1] & w_b[K-1]};
        assign w_loa = {w_hi, w_a[K-1:0] | w_b[K-1:0]};
`ifdef ATREE_EXACT_MODE_EN
        assign w_sum = w_mode[j-1] ? w_loa : ({1'b0, w_a} + {1'b0, w_b});
`else
        assign w_sum = w_loa;
`endif
      end

      assign w_next[i*WJ +: WJ] = w_sum;
    end

    // Advance sums and valid bit one level unless the output is stalled; bubbles move too.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q   <= '0;
        r_vld <= 1'b0;
      end else if (!w_stall) begin
        r_q   <= w_next;
        r_vld <= w_vld[j-1];
      end
    end

    assign w_tree[CO +: NJ*WJ] = r_q;
    assign w_vld[j]            = r_vld;

`ifdef ATREE_EXACT_MODE_EN
    logic r_mode;
    // Carry the operand set's mode alongside its data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_mode <= 1'b0;
      else if (!w_stall) r_mode <= w_mode[j-1];
    end
    assign w_mode[j] = r_mode;
`endif
  end

endmodule

// File: tb/tb_approx_adder_tree_pipe.sv
// tb/tb_approx_adder_tree_pipe.sv - randomized self-checking bench for approx_adder_tree_pipe
module tb_approx_adder_tree_pipe;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int L  = 3;
  localparam int OW = W + L;
  localparam int N2 = 4;
  localparam int W2 = 6;
  localparam int OW2 = W2 + 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, approx_en, out_valid, out_ready;
  logic [N*W-1:0] in_data;
  logic [OW-1:0]  y;
  logic in_valid_k0, in_ready_k0, approx_en_k0, out_valid_k0, out_ready_k0;
  logic [N2*W2-1:0] in_data_k0;
  logic [OW2-1:0]   y_k0;

  int n_cmp  = 0;
  int n_fail = 0;
  longint exp_q[$];

  always #5 clk = ~clk;

  approx_adder_tree_pipe #(.N(N), .W(W), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  approx_adder_tree_pipe #(.N(N2), .W(W2), .K(0)) dut_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_k0), .in_ready(in_ready_k0), .in_data(in_data_k0),
    .approx_en(approx_en_k0), .out_valid(out_valid_k0), .out_ready(out_ready_k0), .y(y_k0)
  );

  // One adder of the reference: exact integer sum, or lower-part-OR built from div/mod arithmetic.
  function automatic longint add_ref(longint a, longint b, int k, bit ap);
    longint m, lo, cin;
    if (!ap || k == 0) return a + b;
    m   = longint'(1) << k;
    lo  = (a % m) | (b % m);
    cin = ((a >> (k - 1)) & (b >> (k - 1))) & 1;
    return (((a >> k) + (b >> k) + cin) << k) + lo;
  endfunction

  // Reduce a list of operands pairwise, level by level, until one value remains.
  function automatic longint tree_ref(logic [511:0] d, int n, int w, int k, bit ap);
    longint v[64];
    int cnt;
    for (int i = 0; i < n; i++) v[i] = longint'(64'(d >> (i * w))) & ((longint'(1) << w) - 1);
    cnt = n;
    while (cnt > 1) begin
      for (int i = 0; i < cnt / 2; i++) v[i] = add_ref(v[2*i], v[2*i+1], k, ap);
      cnt = cnt / 2;
    end
    return v[0];
  endfunction

  function automatic bit eff_mode(bit a);
`ifdef ATREE_EXACT_MODE_EN
    return a;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  task automatic test_reset();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
    if (out_valid !== 1'b0) n_fail++;
    n_cmp++; if (y !== '0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_known_values();
    logic [7:0] pat [4];
    bit         md  [4];
    longint     ex  [4];
    int cyc;
    pat = '{8'h07, 8'h07, 8'hFF, 8'hFF};
    md  = '{1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ATREE_EXACT_MODE_EN
    ex  = '{63, 56, 2047, 2040};
`else
    ex  = '{63, 63, 2047, 2047};
`endif
    for (int c = 0; c < 4; c++) begin
      in_data = {N{pat[c]}};
      approx_en = md[c];
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL known_in_ready[%0d]: got %0b expected 1", c, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      n_cmp++; if (cyc != L) begin n_fail++; $display("FAIL known_latency[%0d]: got %0d expected %0d", c, cyc, L); end
      n_cmp++; if (longint'(y) !== ex[c]) begin n_fail++; $display("FAIL known_y[%0d]: got %0d expected %0d", c, y, ex[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    longint e;
    exp_q.delete();
    out_ready = 1'b1;
    while (got < 24 && cyc < 200) begin
      in_valid = (sent < 24);
      in_data = rand_data();
      approx_en = sent[0];
      #1;
      if (got > 0 && got < 24) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble: got out_valid %0b expected 1 at set %0d", out_valid, got); end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got output %0d expected none", y); end
        else begin
          e = exp_q.pop_front();
          if (longint'(y) !== e) begin n_fail++; $display("FAIL b2b_y[%0d]: got %0d expected %0d", got, y, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(tree_ref(512'(in_data), N, W, K, eff_mode(approx_en))); sent++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 24) begin n_fail++; $display("FAIL b2b_count: got %0d expected 24", got); end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, cyc = 0, stall_left = 0;
    bit stall_done = 0;
    logic [OW-1:0] held = '0;
    longint e;
    exp_q.delete();
    while ((sent < 12 || exp_q.size() > 0) && cyc < 300) begin
      if (!stall_done && out_valid === 1'b1) begin stall_left = 5; held = y; stall_done = 1; end
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      in_valid = (sent < 12);
      in_data = rand_data();
      approx_en = 1'($urandom);
      #1;
      if (stall_left > 0) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
        n_cmp++; if (y !== held || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got y=%0d v=%0b expected y=%0d v=1", y, out_valid, held); end
        stall_left--;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_extra: got output %0d expected none", y); end
        else begin
          e = exp_q.pop_front();
          if (longint'(y) !== e) begin n_fail++; $display("FAIL stall_y[%0d]: got %0d expected %0d", got, y, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(tree_ref(512'(in_data), N, W, K, eff_mode(approx_en))); sent++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got != 12) begin n_fail++; $display("FAIL stall_count: got %0d expected 12", got); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup: got out_valid %0b expected 0", out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      in_data = rand_data();
      approx_en = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: got out_valid %0b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (y !== '0) begin n_fail++; $display("FAIL rstmid_y: got %0d expected 0", y); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %0b expected 1", in_ready); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got out_valid %0b y %0d expected 0", out_valid, y); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0;
    longint e;
    exp_q.delete();
    while ((sent < 150 || exp_q.size() > 0) && cyc < 3000) begin
      in_valid = (sent < 150) && ($urandom_range(0, 9) < 7);
      out_ready = (sent >= 150) || ($urandom_range(0, 9) < 7);
      in_data = rand_data();
      approx_en = 1'($urandom);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra: got output %0d expected none", y); end
        else begin
          e = exp_q.pop_front();
          if (longint'(y) !== e) begin n_fail++; $display("FAIL rand_y[%0d]: got %0d expected %0d", got, y, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(tree_ref(512'(in_data), N, W, K, eff_mode(approx_en))); sent++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got != 150) begin n_fail++; $display("FAIL rand_count: got %0d expected 150", got); end
  endtask

  task automatic test_k0();
    int sent = 0, got = 0, cyc = 0;
    longint e, s;
    longint q[$];
    out_ready_k0 = 1'b1;
    while ((sent < 30 || q.size() > 0) && cyc < 300) begin
      in_valid_k0 = (sent < 30);
      for (int i = 0; i < N2; i++) in_data_k0[i*W2 +: W2] = W2'($urandom);
      approx_en_k0 = (sent < 20) ? 1'b1 : 1'b0;
      #1;
      if (out_valid_k0 === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin n_fail++; $display("FAIL k0_extra: got output %0d expected none", y_k0); end
        else begin
          e = q.pop_front();
          if (longint'(y_k0) !== e) begin n_fail++; $display("FAIL k0_y[%0d]: got %0d expected %0d", got, y_k0, e); end
        end
        got++;
      end
      if (in_valid_k0 && in_ready_k0) begin
        s = 0;
        for (int i = 0; i < N2; i++) s += longint'(in_data_k0[i*W2 +: W2]);
        q.push_back(s);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_k0 = 1'b0;
    n_cmp++; if (got != 30) begin n_fail++; $display("FAIL k0_count: got %0d expected 30", got); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; approx_en = 1'b0; out_ready = 1'b1;
    in_valid_k0 = 1'b0; in_data_k0 = '0; approx_en_k0 = 1'b0; out_ready_k0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_known_values();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    test_k0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

endmodule
